fp_add_cmp_conv_unit: RTL and testbench

- Single-precision (IEEE-754 binary32) floating-point helper unit for the CPU ALU execute stage.
- Provides four operations: add, subtract, signed-int32-to-float conversion, and magnitude compare (used for fmin/fmax).
- Operands are latched with a start strobe; one registered result is produced per operation.

---
 rtl/fp32_pkg.sv | 43 ++++
 rtl/fp32_norm_round.sv | 72 +++++++
 rtl/fp_add_cmp_conv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_fp_add_cmp_conv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared definitions for the single-precision add/compare/convert helper unit.
package fp32_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CONV = 2'b10,
        OP_CMP  = 2'b11
    } fp_op_e;

    typedef enum logic [1:0] {
        CMP_EQ    = 2'b00,
        CMP_GT    = 2'b01,
        CMP_UNORD = 2'b10,
        CMP_LT    = 2'b11
    } cmp_code_e;

    localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
    localparam int          EXP_BIAS = 127;

    // Width of the extended significand handed to the normalise/round stage.
    localparam int NR_SIG_W = 32;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    function automatic logic fp_is_nan(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac != 23'd0);
    endfunction

    function automatic logic fp_is_inf(input fp32_t x);
        return (x.exp == 8'hFF) && (x.frac == 23'd0);
    endfunction

    // Zero and denormal encodings are both treated as signed zero.
    function automatic logic fp_is_zero(input fp32_t x);
        return (x.exp == 8'h00);
    endfunction

endpackage

// File: rtl/fp32_norm_round.sv
// Leading-zero normalise, round-to-nearest-even, overflow-to-Inf and
// flush-to-zero for an unsigned extended significand. The value presented is
// sig_i * 2^(exp_i - bias - (NR_SIG_W-1)): exp_i is the biased exponent the
// result would carry if bit NR_SIG_W-1 of sig_i were the leading one.
module fp32_norm_round
    import fp32_pkg::*;
(
    input  logic                sign_i,
    input  logic signed [9:0]   exp_i,
    input  logic [NR_SIG_W-1:0] sig_i,
    output logic [31:0]         result_o,
    output logic [7:0]          dbg_exp_o,
    output logic [21:0]         dbg_sig_o
);

    logic [5:0]          lzc;
    logic [NR_SIG_W-1:0] norm_sig;
    logic signed [9:0]   norm_exp;
    logic [23:0]         mant;
    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [24:0]         mant_rnd;
    logic signed [9:0]   final_exp;
    logic [22:0]         final_frac;

    // Count leading zeros; the highest set bit wins because it is visited last.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        lzc = 6'd32;
        for (int i = 0; i < NR_SIG_W; i++) begin
            if (sig_i[i]) begin
                lzc = 6'(NR_SIG_W - 1 - i);
            end
        end
    end

    // Normalise, round to nearest even, then classify overflow/underflow.
    always_comb begin
        norm_sig = sig_i << lzc;
        norm_exp = exp_i - signed'({4'b0, lzc});
        mant     = norm_sig[NR_SIG_W-1 -: 24];
        guard    = norm_sig[NR_SIG_W-25];
        sticky   = |norm_sig[NR_SIG_W-26:0];
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {24'b0, round_up};

        // A carry out of rounding leaves exactly 1.000..0, one binade up.
        if (mant_rnd[24]) begin
            final_exp  = norm_exp + 10'sd1;
            final_frac = mant_rnd[23:1];
        end else begin
            final_exp  = norm_exp;
            final_frac = mant_rnd[22:0];
        end

        if (sig_i == '0) begin
            result_o = {sign_i, 31'b0};
        end else if (final_exp >= 10'sd255) begin
            result_o = {sign_i, 8'hFF, 23'b0};
        end else if (final_exp <= 10'sd0) begin
            result_o = {sign_i, 31'b0};
        end else begin
            result_o = {sign_i, final_exp[7:0], final_frac};
        end

        dbg_exp_o = norm_exp[7:0];
        dbg_sig_o = norm_sig[NR_SIG_W-2 -: 22];
    end

endmodule

// File: rtl/fp_add_cmp_conv_unit.sv
// Single-precision add/subtract, int32-to-float conversion and compare for the
// ALU execute stage. Operands are captured on the start edge; the result is
// computed combinationally from that register and written one edge later.
module fp_add_cmp_conv_unit
    import fp32_pkg::*;
#(
    parameter int DEBUG_EN = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic [1:0]  cmp,
    output logic        valid,
    output logic [31:0] debug
);

    // Operand capture stage.
    fp_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        pend_q;

    // Output stage.
    logic [31:0] result_q, result_d;
    logic [1:0]  cmp_q, cmp_d;
    logic        valid_q;
    logic [31:0] debug_q, debug_d;

    // Add/sub datapath.
    fp32_t       fa, fb;
    logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic [30:0] mag_a, mag_b;
    logic        a_big;
    logic [7:0]  exp_x, exp_y, diff;
    logic [23:0] sig_x, sig_y;
    logic        sign_x;
    logic [26:0] ext_x, ext_y, shifted_y, aligned_y;
    logic        align_sticky;
    logic        eff_sub;
    logic [27:0] sum;
    logic        add_sign;
    logic signed [9:0] add_exp;
    logic        special_hit;
    logic [31:0] special_val;

    // Conversion datapath.
    logic        conv_neg;
    logic [31:0] conv_mag;

    // Shared normalise/round stage.
    logic              nr_sign;
    logic signed [9:0] nr_exp;
    logic [NR_SIG_W-1:0] nr_sig;
    logic [31:0]       nr_result;
    logic [7:0]        nr_dbg_exp;
    logic [21:0]       nr_dbg_sig;

    cmp_code_e   cmp_code;

    // Capture operands on the start strobe; pend_q marks a result due next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its sources.
            pend_q <= 1'b0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            pend_q <= start;
            if (start) begin
                op_q <= fp_op_e'(op);
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    // Unpack, order by magnitude and align the smaller operand with G/R/S.
    always_comb begin
        fa = fp32_t'(a_q);
        fb = fp32_t'({b_q[31] ^ (op_q == OP_SUB), b_q[30:0]});

        a_zero = fp_is_zero(fa);
        b_zero = fp_is_zero(fb);
        a_nan  = fp_is_nan(fa);
        b_nan  = fp_is_nan(fb);
        a_inf  = fp_is_inf(fa);
        b_inf  = fp_is_inf(fb);

        mag_a = a_zero ? 31'd0 : {fa.exp, fa.frac};
        mag_b = b_zero ? 31'd0 : {fb.exp, fb.frac};
        a_big = (mag_a >= mag_b);

        exp_x  = a_big ? mag_a[30:23] : mag_b[30:23];
        exp_y  = a_big ? mag_b[30:23] : mag_a[30:23];
        sig_x  = a_big ? {~a_zero, fa.frac & {23{~a_zero}}} : {~b_zero, fb.frac & {23{~b_zero}}};
        sig_y  = a_big ? {~b_zero, fb.frac & {23{~b_zero}}} : {~a_zero, fa.frac & {23{~a_zero}}};
        sign_x = a_big ? fa.sign : fb.sign;
        diff   = exp_x - exp_y;

        ext_x     = {sig_x, 3'b000};
        ext_y     = {sig_y, 3'b000};
        shifted_y = ext_y >> diff;
        // Any bit lost by the shift shows up when shifting back.
        align_sticky = ((shifted_y << diff) != ext_y);
        aligned_y    = {shifted_y[26:1], shifted_y[0] | align_sticky};

        eff_sub = fa.sign ^ fb.sign;
        sum     = eff_sub ? ({1'b0, ext_x} - {1'b0, aligned_y})
                          : ({1'b0, ext_x} + {1'b0, aligned_y});

        // A zero sum is +0 except when both addends are negative zeros.
        add_sign = (sum == 28'd0) ? (fa.sign & fb.sign) : sign_x;
        // sum bit 27 is the carry position, one binade above exp_x.
        add_exp  = signed'({2'b00, exp_x}) + 10'sd1;
    end

    // NaN and infinity operands bypass the arithmetic path.
    always_comb begin
        special_hit = 1'b1;
        special_val = FP_QNAN;
        if (a_nan || b_nan) begin
            special_val = FP_QNAN;
        end else if (a_inf && b_inf) begin
            special_val = (fa.sign != fb.sign) ? FP_QNAN : {fa.sign, 8'hFF, 23'b0};
        end else if (a_inf) begin
            special_val = {fa.sign, 8'hFF, 23'b0};
        end else if (b_inf) begin
            special_val = {fb.sign, 8'hFF, 23'b0};
        end else begin
            special_hit = 1'b0;
        end
    end

    // Feed either the signed-integer magnitude or the add/sub sum to rounding.
    always_comb begin
        conv_neg = a_q[31];
        conv_mag = conv_neg ? (32'd0 - a_q) : a_q;
        if (op_q == OP_CONV) begin
            nr_sign = conv_neg;
            nr_exp  = 10'(EXP_BIAS + NR_SIG_W - 1);
            nr_sig  = conv_mag;
        end else begin
            nr_sign = add_sign;
            nr_exp  = add_exp;
            nr_sig  = {sum, 4'b0000};
        end
    end

    fp32_norm_round u_norm_round (
        .sign_i    (nr_sign),
        .exp_i     (nr_exp),
        .sig_i     (nr_sig),
        .result_o  (nr_result),
        .dbg_exp_o (nr_dbg_exp),
        .dbg_sig_o (nr_dbg_sig)
    );

    // Sign-magnitude ordering of the raw patterns; +0 and -0 are equal.
    always_comb begin
        cmp_code = CMP_EQ;
        if (fp_is_nan(fp32_t'(a_q)) || fp_is_nan(fp32_t'(b_q))) begin
            cmp_code = CMP_UNORD;
        end else if ((a_q[30:0] == 31'd0) && (b_q[30:0] == 31'd0)) begin
            cmp_code = CMP_EQ;
        end else if (a_q == b_q) begin
            cmp_code = CMP_EQ;
        end else if (a_q[31] != b_q[31]) begin
            cmp_code = a_q[31] ? CMP_LT : CMP_GT;
        end else if (!a_q[31]) begin
            cmp_code = (a_q[30:0] > b_q[30:0]) ? CMP_GT : CMP_LT;
        end else begin
            cmp_code = (a_q[30:0] > b_q[30:0]) ? CMP_LT : CMP_GT;
        end
    end

    // Update only the output the pending operation selects; the other holds.
    always_comb begin
        result_d = result_q;
        cmp_d    = cmp_q;
        debug_d  = debug_q;
        if (pend_q) begin
            if (op_q == OP_CMP) begin
                cmp_d = cmp_code;
            end else if ((op_q != OP_CONV) && special_hit) begin
                result_d = special_val;
            end else begin
                result_d = nr_result;
            end
            debug_d = (DEBUG_EN != 0) ? {op_q, nr_dbg_exp, nr_dbg_sig} : 32'd0;
        end
    end

    // Output registers; valid pulses for the cycle after each start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            cmp_q    <= CMP_EQ;
            valid_q  <= 1'b0;
            debug_q  <= '0;
        end else begin
            result_q <= result_d;
            cmp_q    <= cmp_d;
            valid_q  <= pend_q;
            debug_q  <= debug_d;
        end
    end

    assign result = result_q;
    assign cmp    = cmp_q;
    assign valid  = valid_q;
    assign debug  = debug_q;

endmodule

// File: tb/tb_fp_add_cmp_conv_unit.sv
// Self-checking bench for fp_add_cmp_conv_unit: expected outputs are queued as
// each operation is issued and retired by a monitor when valid pulses.
module tb_fp_add_cmp_conv_unit;
    import fp32_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [1:0]  cmp;
    logic        valid;
    logic [31:0] debug;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] res;
        logic [1:0]  cmp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_result;
    logic [1:0]  model_cmp;
    int          checks;
    int          failures;

    fp_add_cmp_conv_unit #(.DEBUG_EN(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .cmp    (cmp),
        .valid  (valid),
        .debug  (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: retire one expected entry per valid pulse.
    always @(negedge clk) begin
        if (!reset && valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: valid=1 with no operation outstanding");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.op == OP_CMP) model_cmp = mon_e.cmp;
                else                    model_result = mon_e.res;
                checks++;
                if (result !== model_result) begin
                    failures++;
                    $display("FAIL %s result: got %h expected %h", mon_e.name, result, model_result);
                end
                checks++;
                if (cmp !== model_cmp) begin
                    failures++;
                    $display("FAIL %s cmp: got %b expected %b", mon_e.name, cmp, model_cmp);
                end
                checks++;
                if (debug[31:30] !== mon_e.op) begin
                    failures++;
                    $display("FAIL %s debug_op: got %b expected %b", mon_e.name, debug[31:30], mon_e.op);
                end
            end
        end
    end

    // Drive one operation for one cycle (caller is at a falling edge) and queue its expectation.
    task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] er, input logic [1:0] ec, input string nm);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        e.op   = o;
        e.res  = er;
        e.cmp  = ec;
        e.name = nm;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Wait, with a cycle budget, until the monitor has retired every queued entry.
    task automatic drain();
        int n = 0;
        start = 1'b0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = OP_ADD;
        a     = 32'h3F80_0000;
        b     = 32'h4000_0000;
        repeat (2) @(negedge clk);
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++; if (cmp !== 2'b00)    begin failures++; $display("FAIL reset_cmp: got %b expected 00", cmp); end
        checks++; if (valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (debug !== 32'd0)  begin failures++; $display("FAIL reset_debug: got %h expected 00000000", debug); end
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle_valid: got %b expected 0", valid); end
        end
        // Start an operation, then reset before it can retire.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin failures++; $display("FAIL mid_op_reset_valid: got %b expected 0", valid); end
        end
        checks++;
        if (result !== 32'd0) begin failures++; $display("FAIL mid_op_reset_result: got %h expected 00000000", result); end
    endtask

    task automatic test_add();
        issue(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2'b00, "add_1p2");
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL add_latency_valid: got %b expected 1", valid); end
        checks++;
        if (result !== 32'h4040_0000) begin failures++; $display("FAIL add_latency_result: got %h expected 40400000", result); end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL add_pulse_width: got %b expected 0", valid); end
        drain();
    endtask

    task automatic test_sub_special();
        issue(OP_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 2'b00, "sub_3m1");
        issue(OP_SUB, 32'h3FC0_0000, 32'h3FC0_0000, 32'h0000_0000, 2'b00, "sub_cancel");
        issue(OP_SUB, 32'h7F80_0000, 32'h7F80_0000, FP_QNAN,       2'b00, "sub_inf_inf");
        issue(OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 2'b00, "add_negzero");
        issue(OP_ADD, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 2'b00, "add_inf_fin");
        issue(OP_ADD, 32'h7F80_0001, 32'h3F80_0000, FP_QNAN,       2'b00, "add_nan");
        issue(OP_ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 2'b00, "add_overflow");
        issue(OP_ADD, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 2'b00, "add_denorm");
        issue(OP_ADD, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 2'b00, "add_opp_cancel");
        drain();
    endtask

    task automatic test_round();
        issue(OP_ADD, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 2'b00, "round_tie_even");
        issue(OP_ADD, 32'h4B80_0000, 32'h4040_0000, 32'h4B80_0002, 2'b00, "round_up");
        drain();
    endtask

    task automatic test_conv();
        issue(OP_CONV, 32'h0000_0005, 32'h0, 32'h40A0_0000, 2'b00, "conv_5");
        issue(OP_CONV, 32'hFFFF_FFFF, 32'h0, 32'hBF80_0000, 2'b00, "conv_m1");
        issue(OP_CONV, 32'h8000_0000, 32'h0, 32'hCF00_0000, 2'b00, "conv_intmin");
        issue(OP_CONV, 32'h0100_0001, 32'h0, 32'h4B80_0000, 2'b00, "conv_tie");
        issue(OP_CONV, 32'h0000_0000, 32'h0, 32'h0000_0000, 2'b00, "conv_zero");
        issue(OP_CONV, 32'h01FF_FFFF, 32'h0, 32'h4C00_0000, 2'b00, "conv_renorm");
        issue(OP_CONV, 32'h7FFF_FFFF, 32'h0, 32'h4F00_0000, 2'b00, "conv_intmax");
        drain();
    endtask

    task automatic test_cmp();
        issue(OP_CMP, 32'h3F80_0000, 32'h4000_0000, 32'h0, CMP_LT,    "cmp_1_2");
        issue(OP_CMP, 32'h4000_0000, 32'h3F80_0000, 32'h0, CMP_GT,    "cmp_2_1");
        issue(OP_CMP, 32'h8000_0000, 32'h0000_0000, 32'h0, CMP_EQ,    "cmp_zeros");
        issue(OP_CMP, 32'hC000_0000, 32'hBF80_0000, 32'h0, CMP_LT,    "cmp_neg");
        issue(OP_CMP, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, CMP_UNORD, "cmp_nan");
        issue(OP_CMP, 32'hBF80_0000, 32'h3F80_0000, 32'h0, CMP_LT,    "cmp_mixed_sign");
        issue(OP_CMP, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h0, CMP_GT,    "cmp_inf");
        issue(OP_CMP, 32'h3F80_0000, 32'h3F80_0000, 32'h0, CMP_EQ,    "cmp_equal");
        drain();
    endtask

    task automatic test_back_to_back();
        issue(OP_ADD,  32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2'b00,  "b2b_add");
        issue(OP_CMP,  32'h4000_0000, 32'h3F80_0000, 32'h0,         CMP_GT, "b2b_cmp");
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_1: got %b expected 1", valid); end
        issue(OP_CONV, 32'h0000_0005, 32'h0,         32'h40A0_0000, 2'b00,  "b2b_conv");
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_2: got %b expected 1", valid); end
        issue(OP_SUB,  32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 2'b00,  "b2b_sub");
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_3: got %b expected 1", valid); end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_4: got %b expected 1", valid); end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_end: got %b expected 0", valid); end
        drain();
    endtask

    // Global bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        model_result = 32'd0;
        model_cmp    = 2'b00;
        test_reset();
        test_add();
        test_sub_special();
        test_round();
        test_conv();
        test_cmp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
